// File: rtl/serial_frame_tx_pkg.sv
// rtl/serial_frame_tx_pkg.sv - shared state encodings and line levels for serial framing
package serial_frame_tx_pkg;

  // Frame sequencer states; encodings are fixed so other serial blocks can share them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } frame_state_e;

  // Serial line levels seen by the downstream shift-register chain.
  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/serial_frame_tx_piso_shift_reg.sv
// rtl/serial_frame_tx_piso_shift_reg.sv - parallel-in serial-out shift register, MSB first
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  // Clear wins over load, load wins over shift; shift-left feeds zeros in at the bottom.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q <= '0;
    end else if (ld) begin
      sr_q <= d;
    end else if (sh) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - framing transmitter: start, data MSB first, optional parity, stop
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  frame_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic          par_q;
  logic          out_q;
  logic          busy_q;
  logic          done_q;
  logic          sr_msb;
  logic          accept;

  // A new word can be taken while idle or during the stop bit of the previous frame.
  assign ready  = ((state_q == ST_IDLE) || (state_q == ST_STOP)) && !clr;
  assign accept = load && ready;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sr (
    .clk(clk),
    .clr(clr),
    .ld (accept),
    .sh (state_q == ST_DATA),
    .d  (data_in),
    .msb(sr_msb)
  );

  // Frame sequencer; line, busy and done are registered so they trail the state by one edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      out_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_q != ST_IDLE);
      done_q <= (state_q == ST_STOP);
      case (state_q)
        ST_IDLE: begin
          out_q <= LINE_IDLE;
          if (accept) begin
            cnt_q   <= CNT_LAST;
            par_q   <= (^data_in) ^ PAR_INV;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          out_q   <= LINE_START;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          out_q <= sr_msb;
          if (cnt_q == '0) begin
            state_q <= (PARITY_EN != 0) ? ST_PAR : ST_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PAR: begin
          out_q   <= par_q;
          state_q <= ST_STOP;
        end
        ST_STOP: begin
          out_q <= LINE_STOP;
          if (accept) begin
            // Parity is latched from the same word the shift register captures this edge.
            cnt_q   <= CNT_LAST;
            par_q   <= (^data_in) ^ PAR_INV;
            state_q <= ST_START;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          out_q   <= LINE_IDLE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out framing transmitter.
- It is the sending end for the team's serial shift-register links.
- It accepts a WIDTH-bit word through a valid/ready handshake, then drives it onto a single-bit line, one bit per clock.
- Each frame has a start bit, the data bits MSB first, an optional parity bit and a stop bit.
- The downstream shift-register chain, clocked by the same clk, samples the line.

Parameters:
- WIDTH, 4: data word width, >= 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.

Ports:
- clk  input  1  single clock, all state changes on its rising edge.
- clr  input  1  reset, synchronous, active-high.
- data_in  input  WIDTH  word to send, sampled only on an accepted load.
- load  input  1  request valid. Accepted when load && ready at a rising edge.
- ready  output  1  block can accept a word this cycle.
- out  output  1  registered serial line.
- busy  output  1  a frame is in progress (START, DATA, PAR or STOP).
- done  output  1  one-cycle pulse, coincident with the stop bit.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high on clr.
  - While clr=1 at an edge: state=IDLE, out=0, busy=0, done=0, shift register and counter cleared.
  - ready=0 combinationally while clr=1.
- Line levels: idle=0, start bit=1, stop bit=0.
- States: IDLE, START, DATA, PAR, STOP.
- ready = (state==IDLE || state==STOP) && !clr.
- IDLE:
  - On load && ready: data_in is captured into the shift register, the bit counter is set to WIDTH-1, and the next state is START.
  - Otherwise stay in IDLE with out=0.
- START:
  - out=1 for exactly one cycle.
  - Next state: DATA.
- DATA:
  - out = shift-register MSB; shift left each cycle.
  - The counter decrements. When it reaches 0, next state is PAR if PARITY_EN, else STOP.
- PAR:
  - out = XOR of the captured word, XOR PARITY_ODD.
  - Next state: STOP.
- STOP:
  - out=0 and done=1 for this one cycle.
  - If load is accepted in this cycle: capture data_in and go to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- Latency:
  - The accept edge is edge k. The start bit is visible after edge k+1.
  - Data bit i (MSB first) appears after edge k+2+i.
  - Frame length is WIDTH+2+PARITY_EN cycles.
- load outside IDLE/STOP: ignored. data_in is not sampled, and no queueing is performed.
- data_in changing mid-frame: has no effect on the frame in progress.
- Parity source: computed from the captured copy, never from live data_in.
- Reset mid-frame:
  - The frame is discarded, with no done pulse.
  - out=0 from the next edge.
  - ready returns the cycle after clr deasserts.
- load held continuously: every frame is followed immediately by the next one. Each frame samples data_in during its STOP cycle.
- busy: 1 in START/DATA/PAR/STOP, 0 in IDLE. busy stays 1 across back-to-back frames.

Decomposition:
- Shared include file:
  - State encodings as localparam/define: IDLE=0, START=1, DATA=2, PAR=3, STOP=4, 3 bits.
  - Line-level constants LINE_IDLE=0, LINE_START=1, LINE_STOP=0.
- One natural sub-module: piso_shift_reg.
  - Parameterised by WIDTH.
  - Ports: clk, clr, ld, sh, d[WIDTH], msb.
  - Parallel load, shift-left-by-one, synchronous clear.
  - Reused by later serial blocks.
- Control FSM, bit counter and parity logic stay in serial_frame_tx.

Test Plan:
1. Reset and idle:
   - Stimulus: clr=1 for 2 edges, then clr=0, load=0 for 10 cycles.
   - Required: out=0, busy=0, done=0 throughout; ready=0 during clr and 1 after.
2. Single frame, WIDTH=4, PARITY_EN=0:
   - Stimulus: load=1 with data_in=4'b0011 for one cycle.
   - Required: out=1,0,0,1,1,0 on the following 6 cycles.
   - done=1 only on the 6th; busy=1 for exactly 6 cycles; ready=0 on cycles 1-5.
3. Parity, PARITY_EN=1:
   - Stimulus: data_in=4'b1011.
   - Required with PARITY_ODD=0: out=1,1,0,1,1,1,0.
   - Required with PARITY_ODD=1: parity bit=0, i.e. out=1,1,0,1,1,0,0.
4. Back-to-back:
   - Stimulus: load held high, data_in=4'b1100, then 4'b0101 presented during the first STOP cycle.
   - Required: out=1,1,1,0,0,0,1,0,1,0,1,0.
   - No idle cycle between frames; done pulses twice; busy never drops.
5. Ignored load and input stability:
   - Stimulus: send 4'b1001; during DATA assert load with data_in=4'b0110 and toggle data_in every cycle.
   - Required: serial bits 1,0,0,1 are unaffected; no second frame starts.
6. Reset mid-frame:
   - Stimulus: assert clr for one edge during the 2nd data bit of 4'b1111.
   - Required: out=0 from the next edge, no done pulse, state IDLE.
   - A new load sent 2 cycles later transmits a correct full frame.
